// File: rtl/mem_pkg.sv
// Shared definitions for the wait-stated memory responder: state encodings
// and default geometry/timing.
package mem_pkg;

    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_STATES = 2;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_READ_WAIT    = 3'd1,
        ST_READ_DONE    = 3'd2,
        ST_WRITE_COMMIT = 3'd3,
        ST_FAULT        = 3'd4
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents start at zero and are never touched by reset.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write at a time in Idle, inserts
// wait states on reads and reports completion with a one-cycle Ready pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        Err,
    output logic [2:0]  StateOut
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_index;
    logic [31:0]     r_wdata;
    logic            r_both;
    logic            r_ready;
    logic            r_err;
    logic [31:0]     r_rdata;

    logic [31:0]     w_mem_rdata;
    logic            w_mem_we;
    logic            w_addr_unused;

    // Bits above the word index are ignored so the address space wraps.
    assign w_addr_unused = ^Address[31:AW+2];

    // The write lands on the edge that leaves Write_Commit, so an async
    // reset inside that cycle drops the state and the write never happens.
    assign w_mem_we = (r_state == ST_WRITE_COMMIT);

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (Clk),
        .i_we    (w_mem_we),
        .i_addr  (r_index),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_index <= '0;
            r_wdata <= '0;
            r_both  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MemRead || MemWrite) begin
                        r_index <= Address[AW+1:2];
                        r_wdata <= WriteData;
                        r_both  <= MemRead && MemWrite;
                        if (Address[1:0] != 2'b00) begin
                            r_state <= ST_FAULT;
                        end else if (MemWrite) begin
                            r_state <= ST_WRITE_COMMIT;
                        end else begin
                            r_state <= ST_READ_WAIT;
                            r_cnt   <= CW'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_READ_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_READ_DONE: begin
                    r_ready <= 1'b1;
                    r_rdata <= w_mem_rdata;
                    r_state <= ST_IDLE;
                end
                ST_WRITE_COMMIT: begin
                    r_ready <= 1'b1;
                    r_err   <= r_both;
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    r_ready <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ReadData = r_rdata;
    assign Ready    = r_ready;
    assign Err      = r_err;
    assign Busy     = (r_state != ST_IDLE);
    assign StateOut = r_state;

endmodule
